fetch_sequencer: RTL

Program-counter and fetch controller for the 16-bit single-issue core. Owns the 3-bit PC, drives the combinational instruction memory address, registers the returned word into a one-entry output buffer, and hands it to decode over a valid/ready handshake. Supports start, branch/jump redirect, backpressure, and end-of-program halt.

---
 rtl/fetch_sequencer_pkg.sv | 30 +++
 rtl/fetch_sequencer_buffer.sv | 66 ++++++
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared constants and types for the fetch sequencer:
//   PC_W / INSTR_W  - program counter and instruction widths
//   RESET_PC        - PC after reset
//   HALT_WORD       - all-zero word (NOP, or program terminator when
//                     FETCH_HALT_ZERO_EN is defined)
//   state_e         - fetch FSM state encoding
//   pc_inc()        - modulo-2^PC_W PC increment
// ---------------------------------------------------------------------------
package fetch_sequencer_pkg;

  localparam int PC_W    = 3;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0]    RESET_PC  = 3'd0;
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Wraps naturally from all-ones back to zero.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 3'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_buffer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_buffer (fetch_buffer)
// One-entry valid/ready holding register with flush.
//   clk, rst_n   - clock, async active-low reset
//   load_i       - capture data_i/pc_i and mark valid
//   flush_i      - drop the held word (wins over load_i)
//   ready_i      - consumer accepts the held word this cycle
//   data_o/pc_o  - held word and the address it came from
//   valid_o      - held word not yet delivered
// ---------------------------------------------------------------------------
module fetch_sequencer_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               ready_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] data_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] data_q, data_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;

  // Next-state for the holding register; data is only replaced on load so the
  // word stays stable under backpressure.
  always_comb begin
    data_d  = data_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 16'h0000;
      pc_q    <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// PC and fetch controller: owns the PC, addresses instruction memory, buffers
// the returned word and hands it to decode over valid/ready.
//   start                    - leave IDLE and begin fetching
//   imem_addr / imem_data    - combinational instruction memory port
//   instr_out/pc/valid/ready - decode handshake
//   redirect_valid/pc        - branch/jump redirect (highest priority)
//   halted                   - in HALT (only with FETCH_HALT_ZERO_EN)
//   pc_wrap                  - pulse after PC advances all-ones -> 0
//   fetch_count              - saturating delivered-word count
// Config macro: FETCH_HALT_ZERO_EN - an all-zero word halts the program.
// ---------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted,
  output logic               pc_wrap,
  output logic [7:0]         fetch_count
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic            pc_wrap_q, pc_wrap_d;
  logic [7:0]      count_q, count_d;

  logic capture_s, halt_hit_s, load_s, flush_s, deliver_s;

  // A redirect suppresses any capture in the same cycle.
  assign capture_s = (state_q == ST_FETCH) && (!instr_valid || instr_ready)
                     && !redirect_valid;
`ifdef FETCH_HALT_ZERO_EN
  assign halt_hit_s = capture_s && (imem_data == HALT_WORD);
`else
  assign halt_hit_s = 1'b0;
`endif
  assign load_s    = capture_s && !halt_hit_s;
  assign flush_s   = redirect_valid || halt_hit_s;
  assign deliver_s = instr_valid && instr_ready;

  // FSM, PC and status next-state; redirect overrides start, capture and halt.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    pc_wrap_d = 1'b0;
    if (redirect_valid) begin
      state_d  = ST_FETCH;
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_FETCH;
          else       state_d = ST_IDLE;
        end
        ST_FETCH: begin
          if (halt_hit_s) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (load_s) begin
            pc_d      = pc_inc(pc_q);
            pc_wrap_d = (pc_q == {PC_W{1'b1}});
          end else begin
            pc_d = pc_q;
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: begin
          state_d  = ST_IDLE;
          halted_d = 1'b0;
        end
      endcase
    end
    // A word delivered in the same cycle as a redirect or halt still counts.
    if (deliver_s && (count_q != 8'hFF)) count_d = count_q + 8'd1;
    else                                   count_d = count_q;
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      halted_q  <= 1'b0;
      pc_wrap_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      pc_wrap_q <= pc_wrap_d;
      count_q   <= count_d;
    end
  end

  fetch_sequencer_buffer u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_s),
    .flush_i (flush_s),
    .ready_i (instr_ready),
    .data_i  (imem_data),
    .pc_i    (pc_q),
    .data_o  (instr_out),
    .pc_o    (instr_pc),
    .valid_o (instr_valid)
  );

  assign imem_addr   = pc_q;
  assign halted      = halted_q;
  assign pc_wrap     = pc_wrap_q;
  assign fetch_count = count_q;

endmodule
